// File: rtl/div_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
package div_pkg;

  localparam int W_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/div_datapath.sv
// Divider datapath: remainder, divisor and quotient registers plus the
// subtractor and the status signals the controller steers on.
module div_datapath #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] data_in,
  input  logic         ld_r,
  input  logic         ld_d,
  input  logic         clr_q,
  input  logic         sub,
  output logic         ge,
  output logic         dz,
  output logic [W-1:0] q_val,
  output logic [W-1:0] r_val
);

  logic [W-1:0] r_reg;
  logic [W-1:0] d_reg;
  logic [W-1:0] q_reg;

  // R holds the dividend first and then shrinks by D on each accepted step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg <= '0;
      d_reg <= '0;
      q_reg <= '0;
    end else begin
      if (ld_r) begin
        r_reg <= data_in;
      end else if (sub) begin
        r_reg <= r_reg - d_reg;
      end
      if (ld_d) begin
        d_reg <= data_in;
      end
      if (clr_q) begin
        q_reg <= '0;
      end else if (sub) begin
        q_reg <= q_reg + 1'b1;
      end
    end
  end

  assign ge    = (r_reg >= d_reg);
  assign dz    = (d_reg == '0);
  assign q_val = q_reg;
  assign r_val = r_reg;

endmodule

// File: rtl/div_seq_sub.sv
// Sequential unsigned divider: controller FSM driving div_datapath, one
// subtraction per CALC cycle, with a divide-by-zero flag.
module div_seq_sub
  import div_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero,
  output logic         busy,
  output logic         done
);

  state_t state;
  state_t next_state;

  logic ld_r;
  logic ld_d;
  logic clr_q;
  logic sub;
  logic set_dz;
  logic ge;
  logic dz;
  logic dz_flag;

  div_datapath #(.W(W)) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .ld_r    (ld_r),
    .ld_d    (ld_d),
    .clr_q   (clr_q),
    .sub     (sub),
    .ge      (ge),
    .dz      (dz),
    .q_val   (quotient),
    .r_val   (remainder)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dz_flag <= 1'b0;
    end else begin
      state <= next_state;
      if (clr_q) begin
        dz_flag <= 1'b0;
      end else if (set_dz) begin
        dz_flag <= 1'b1;
      end
    end
  end

  // DONE waits for start to fall so a held request yields a single operation.
  always_comb begin
    next_state = state;
    ld_r       = 1'b0;
    ld_d       = 1'b0;
    clr_q      = 1'b0;
    sub        = 1'b0;
    set_dz     = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD_A;
      end
      LOAD_A: begin
        ld_r       = 1'b1;
        next_state = LOAD_B;
      end
      LOAD_B: begin
        ld_d       = 1'b1;
        clr_q      = 1'b1;
        next_state = CALC;
      end
      CALC: begin
        if (dz) begin
          set_dz     = 1'b1;
          next_state = DONE;
        end else if (ge) begin
          sub = 1'b1;
        end else begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (!start) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy        = (state == LOAD_A) || (state == LOAD_B) || (state == CALC);
  assign done        = (state == DONE);
  assign div_by_zero = dz_flag;

endmodule

// File: tb/tb_div_seq_sub.sv
// Scoreboard bench for div_seq_sub: expected results come from plain
// integer division and are checked by a monitor on each rising done.
module tb_div_seq_sub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;
  logic         done;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
    int e0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   mon_j;
  int   trace_act = 0;
  int   trace_exp = 0;
  bit   trace_bad = 1'b0;
  bit   done_q = 1'b0;

  div_seq_sub #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .data_in     (data_in),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Issues one operation and pushes its expected result; start drops after e0 unless held.
  task automatic applyStimulus(input int a, input int b, input bit hold);
    exp_t e;
    @(negedge clk);
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = 0; e.r = a; e.dz = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 0;
    end
    e.e0 = cyc + 1;
    sb.push_back(e);
    busy_cnt  = 0;
    trace_bad = 1'b0;
    trace_act = 0;
    trace_exp = 0;
    start     = 1'b1;
    data_in   = W'($urandom);
    @(negedge clk);
    data_in = a[W-1:0];
    if (!hold) start = 1'b0;
    @(negedge clk);
    data_in = b[W-1:0];
    @(negedge clk);
    data_in = W'($urandom);
  endtask

  task automatic waitDone(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: got done=0 after %0d cycles, expected done=1", budget);
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  task automatic releaseStart();
    start = 1'b0;
    @(negedge clk);
    checkOutput("done_drop", int'(done), 0);
    checkOutput("idle_busy", int'(busy), 0);
  endtask

  task automatic runOp(input int a, input int b);
    applyStimulus(a, b, 1'b0);
    waitDone(70000);
    releaseStart();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_quotient"}, int'(quotient), 0);
    checkOutput({tag, "_remainder"}, int'(remainder), 0);
    checkOutput({tag, "_dz"}, int'(div_by_zero), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
  endtask

  // Monitor: traces Q/R during CALC and scores each completed operation.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_q = 1'b0;
    end else begin
      if (sb.size() > 0 && busy && cyc >= sb[0].e0 + 2) begin
        mon_j = cyc - sb[0].e0 - 2;
        if (!trace_bad && (int'(quotient) != mon_j ||
                           int'(remainder) != sb[0].a - mon_j * sb[0].b)) begin
          trace_bad = 1'b1;
          trace_act = int'(quotient) * 65536 + int'(remainder);
          trace_exp = mon_j * 65536 + (sb[0].a - mon_j * sb[0].b);
        end
      end
      if (busy) busy_cnt++;
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no completion", cyc);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("quotient", int'(quotient), mon_e.q);
          checkOutput("remainder", int'(remainder), mon_e.r);
          checkOutput("div_by_zero", int'(div_by_zero), mon_e.dz);
          checkOutput("done_edge", cyc, mon_e.e0 + 3 + mon_e.q);
          checkOutput("busy_cycles", busy_cnt, 3 + mon_e.q);
          checkOutput("trace_qr", trace_act, trace_exp);
        end
      end
      done_q = done;
    end
  end

  initial begin
    int a;
    int b;
    int sel;
    int low_cnt;

    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    runOp(17, 5);
    runOp(5, 17);
    runOp(100, 0);
    runOp(40, 8);
    runOp(0, 7);
    runOp(65535, 65535);
    runOp(65535, 1);

    applyStimulus(23, 6, 1'b1);
    waitDone(1000);
    low_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (done !== 1'b1) low_cnt++;
    end
    checkOutput("held_done_low_cycles", low_cnt, 0);
    releaseStart();
    runOp(9, 4);

    applyStimulus(17, 5, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    runOp(17, 5);

    for (int i = 0; i < 20; i++) begin
      a   = int'($urandom_range(0, 65535));
      sel = int'($urandom_range(0, 7));
      if (sel == 0) begin
        b = 0;
      end else if (sel < 3) begin
        a = int'($urandom_range(0, 2000));
        b = int'($urandom_range(1, 20));
      end else begin
        b = int'($urandom_range(1, 65535));
      end
      if (b != 0 && a / b > 500) b = a / 500 + 1;
      runOp(a, b);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
